// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline front end: pixel and buffer types,
// group geometry and the pixel-buffer loader state encoding.
package sobel_pkg;

  typedef logic [23:0] pixel_t;
  typedef logic [3:0][23:0] pix_buf_t;

  localparam int WORDS_PER_GROUP = 3;
  localparam int PIX_PER_GROUP   = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE
  } loader_state_t;

endpackage

// File: rtl/rgb_unpacker.sv
// Combinational unpacker: three 32-bit words carrying four packed 24-bit
// {R,G,B} pixels, in arrival order w0,w1,w2, become one 4-pixel buffer.
module rgb_unpacker
  import sobel_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  output pix_buf_t    pix_buf
);

  // Pixels straddle word boundaries; each pixel takes the next 24 bits of the stream
  always_comb begin
    pix_buf[0] = w0[23:0];
    pix_buf[1] = {w1[15:0], w0[31:24]};
    pix_buf[2] = {w2[7:0], w1[31:16]};
    pix_buf[3] = w2[31:8];
  end

endmodule

// File: rtl/pixel_buffer_loader.sv
// Producer side of the grayscale pixel-buffer interface. Collects three packed
// RGB words per group, presents the unpacked 4-pixel buffer with gray_en and
// waits for gray_done, counting groups until the frame is complete.
// Optional macro LOADER_PREFETCH_EN: keeps accepting words of the next group
// while the current buffer is being consumed, so gray_en stays high across
// groups when the next group is already complete.
module pixel_buffer_loader
  import sobel_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int CNT_W      = $clog2(NUM_GROUPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output pix_buf_t         out_pixel_buffer,
  output logic             gray_en,
  input  logic             gray_done,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] group_cnt
);

  loader_state_t    state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      w0_q, w0_d, w1_q, w1_d;
  pix_buf_t         buf_q, buf_d, unpacked;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fd_q, fd_d;
  logic             accept;
  logic             last_group;
  logic [31:0]      third_word;
`ifdef LOADER_PREFETCH_EN
  logic [31:0]      w2_q, w2_d;
`endif

  assign accept     = in_valid & in_ready;
  assign last_group = (cnt_q == CNT_W'(NUM_GROUPS - 1));

`ifdef LOADER_PREFETCH_EN
  // A full shadow supplies its stored third word; otherwise the third word is on the bus
  assign third_word = (idx_q == 2'd3) ? w2_q : in_word;
`else
  assign third_word = in_word;
`endif

  rgb_unpacker u_unpacker (
    .w0      (w0_q),
    .w1      (w1_q),
    .w2      (third_word),
    .pix_buf (unpacked)
  );

  // Words are only taken while filling, or while prefetching a group that still belongs to the frame
  always_comb begin
    in_ready = (state_q == FILL);
`ifdef LOADER_PREFETCH_EN
    if (state_q == ISSUE && idx_q != 2'd3 && !last_group) begin
      in_ready = 1'b1;
    end
`endif
  end

  // Next-state and datapath: word collection, buffer load and gray handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
`ifdef LOADER_PREFETCH_EN
    w2_d    = w2_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          unique case (idx_q)
            2'd0: begin
              w0_d  = in_word;
              idx_d = 2'd1;
            end
            2'd1: begin
              w1_d  = in_word;
              idx_d = 2'd2;
            end
            default: begin
              buf_d   = unpacked;
              idx_d   = 2'd0;
              state_d = ISSUE;
            end
          endcase
        end
      end
      ISSUE: begin
`ifdef LOADER_PREFETCH_EN
        if (accept) begin
          unique case (idx_q)
            2'd0: begin
              w0_d  = in_word;
              idx_d = 2'd1;
            end
            2'd1: begin
              w1_d  = in_word;
              idx_d = 2'd2;
            end
            2'd2: begin
              w2_d  = in_word;
              idx_d = 2'd3;
            end
            default: begin
            end
          endcase
        end
`endif
        if (gray_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_group) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            fd_d    = 1'b1;
          end else begin
`ifdef LOADER_PREFETCH_EN
            if (idx_q == 2'd3 || (accept && idx_q == 2'd2)) begin
              buf_d = unpacked;
              idx_d = 2'd0;
            end else begin
              state_d = FILL;
            end
`else
            state_d = FILL;
            idx_d   = 2'd0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that drops any partial group
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
`ifdef LOADER_PREFETCH_EN
      w2_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
`ifdef LOADER_PREFETCH_EN
      w2_q    <= w2_d;
`endif
    end
  end

  assign out_pixel_buffer = buf_q;
  assign gray_en          = (state_q == ISSUE);
  assign busy             = (state_q != IDLE);
  assign frame_done       = fd_q;
  assign group_cnt        = cnt_q;

endmodule

// File: tb/tb_pixel_buffer_loader.sv
// Self-checking bench for pixel_buffer_loader: a vector table on a
// single-group instance, then directed and random sequences on a four-group
// instance checked against a stream-level reference model.
module tb_pixel_buffer_loader;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0, valid1 = 1'b0, done1 = 1'b0;
  logic [31:0] word1 = '0;
  logic        ready1, gray1, busy1, fd1;
  logic [3:0][23:0] buf1;
  logic [0:0]  cnt1;

  logic        start4 = 1'b0, valid4 = 1'b0, done4 = 1'b0;
  logic [31:0] word4 = '0;
  logic        ready4, gray4, busy4, fd4;
  logic [3:0][23:0] buf4;
  logic [2:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 tb_clk = ~tb_clk;

  pixel_buffer_loader #(.NUM_GROUPS(1)) dut1 (
    .clk(tb_clk), .rst(rst), .start(start1), .in_word(word1), .in_valid(valid1),
    .in_ready(ready1), .out_pixel_buffer(buf1), .gray_en(gray1), .gray_done(done1),
    .busy(busy1), .frame_done(fd1), .group_cnt(cnt1)
  );

  pixel_buffer_loader #(.NUM_GROUPS(4)) dut4 (
    .clk(tb_clk), .rst(rst), .start(start4), .in_word(word4), .in_valid(valid4),
    .in_ready(ready4), .out_pixel_buffer(buf4), .gray_en(gray4), .gray_done(done4),
    .busy(busy4), .frame_done(fd4), .group_cnt(cnt4)
  );

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Table vectors for the one-group instance
  typedef struct {
    logic        rst, start, valid;
    logic [31:0] word;
    logic        done;
    logic        e_ready, e_gray, e_busy, e_fd;
    logic        e_cnt;
    logic [95:0] e_buf;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic v, logic [31:0] w, logic d,
                              logic er, logic eg, logic eb, logic ef, logic ec, logic [95:0] ebuf);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.word = w; t.done = d;
    t.e_ready = er; t.e_gray = eg; t.e_busy = eb; t.e_fd = ef; t.e_cnt = ec; t.e_buf = ebuf;
    return t;
  endfunction

  // Reference model for the four-group instance: state of the frame at stream level
  localparam int MODEL_GROUPS = 4;
  bit          m_busy = 0, m_issuing = 0, m_fd = 0;
  int          m_groups = 0;
  logic [95:0] m_buf = '0;
  logic [31:0] m_q[$];

  task automatic modelUpdate(input bit r, input bit s, input bit v, input logic [31:0] w, input bit d);
    m_fd = 0;
    if (r) begin
      m_busy = 0; m_issuing = 0; m_groups = 0; m_buf = '0; m_q.delete();
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_groups = 0; m_q.delete();
      end
    end else if (!m_issuing) begin
      if (v) begin
        m_q.push_back(w);
        if (m_q.size() == 3) begin
          m_buf = {m_q[2], m_q[1], m_q[0]};
          m_q.delete();
          m_issuing = 1;
        end
      end
    end else if (d) begin
      m_groups++;
      m_issuing = 0;
      if (m_groups == MODEL_GROUPS) begin
        m_busy = 0;
        m_fd = 1;
      end
    end
  endtask

  // One cycle on the four-group instance: drive, compare current outputs, advance model
  task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [31:0] w, input bit d);
    rst = r; start4 = s; valid4 = v; word4 = w; done4 = d;
    #1;
    checkOutput("in_ready", 96'(ready4), 96'(m_busy && !m_issuing));
    checkOutput("gray_en", 96'(gray4), 96'(m_issuing));
    checkOutput("busy", 96'(busy4), 96'(m_busy));
    checkOutput("frame_done", 96'(fd4), 96'(m_fd));
    checkOutput("group_cnt", 96'(cnt4), 96'(m_groups));
    checkOutput("buffer", buf4, m_buf);
    modelUpdate(r, s, v, w, d);
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic sendWords(input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) applyStimulus(0, 0, 0, $urandom, 0);
      applyStimulus(0, 0, 1, $urandom, 0);
    end
  endtask

  vec_t tbl[11];
  localparam logic [95:0] T2_BUF = 96'hFFEEDD_102030_0A0B0C_01C109;

  initial begin
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, '0);
    tbl[1]  = mk(1, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, '0);
    tbl[2]  = mk(0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, '0);
    tbl[3]  = mk(0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, '0);
    tbl[4]  = mk(0, 0, 1, 32'h0C01C109, 0, 1, 0, 1, 0, 0, '0);
    tbl[5]  = mk(0, 0, 1, 32'h20300A0B, 0, 1, 0, 1, 0, 0, '0);
    tbl[6]  = mk(0, 0, 1, 32'hFFEEDD10, 0, 0, 1, 1, 0, 0, T2_BUF);
    tbl[7]  = mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, T2_BUF);
    tbl[8]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 1, 1, T2_BUF);
    tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, T2_BUF);
    tbl[10] = mk(0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, T2_BUF);

    $display("[TB] single-group vector table");
    @(negedge tb_clk);
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; start1 = tbl[i].start; valid1 = tbl[i].valid;
      word1 = tbl[i].word; done1 = tbl[i].done;
      @(posedge tb_clk);
      @(negedge tb_clk);
      checkOutput($sformatf("t1_ready[%0d]", i), 96'(ready1), 96'(tbl[i].e_ready));
      checkOutput($sformatf("t1_gray[%0d]", i), 96'(gray1), 96'(tbl[i].e_gray));
      checkOutput($sformatf("t1_busy[%0d]", i), 96'(busy1), 96'(tbl[i].e_busy));
      checkOutput($sformatf("t1_fd[%0d]", i), 96'(fd1), 96'(tbl[i].e_fd));
      checkOutput($sformatf("t1_cnt[%0d]", i), 96'(cnt1), 96'(tbl[i].e_cnt));
      checkOutput($sformatf("t1_buf[%0d]", i), buf1, tbl[i].e_buf);
    end
    start1 = 0; valid1 = 0; done1 = 0;

    $display("[TB] reset and stall on four-group instance");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'hAAAA5555, 0);
    applyStimulus(0, 0, 1, 32'hAAAA5555, 0);
    applyStimulus(0, 1, 0, 0, 0);
    sendWords(3, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, $urandom, 0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] gapped input and spurious events");
    for (int g = 1; g < 4; g++) begin
      if (g == 2) begin
        sendWords(1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        sendWords(2, 1);
      end else begin
        sendWords(3, 1);
      end
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("final_cnt", 96'(cnt4), 96'd4);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] reset mid-fill");
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h11111111, 0);
    applyStimulus(0, 0, 1, 32'h22222222, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'hA1B2C3D4, 0);
    applyStimulus(0, 0, 1, 32'hE5F60718, 0);
    applyStimulus(0, 0, 1, 32'h293A4B5C, 0);
    checkOutput("fresh_buf", buf4, 96'h293A4B5C_E5F60718_A1B2C3D4);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 97) == 0, ($urandom % 6) == 0, $urandom % 2,
                    $urandom, ($urandom % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
